cpu_launcher: RTL and testbench

CPU_LAUNCHER -- requirements
Module: cpu_launcher

---
 rtl/cpu_launcher_pkg.sv | 28 ++
 rtl/cpu_launcher_timer.sv | 36 +++
 rtl/cpu_launcher.sv | 188 ++++++++++++++++++
 tb/tb_cpu_launcher.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_launcher_pkg.sv
// cpu_launcher_pkg
//   Shared definitions for the CPU launcher: FSM state encoding, report
//   status codes and default parameter values.
package cpu_launcher_pkg;

  localparam int ADDR_W_DEF  = 13;
  localparam int TIMEOUT_DEF = 4096;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_LOAD     = 4'd1,
    ST_ARM      = 4'd2,
    ST_START_HI = 4'd3,
    ST_START_LO = 4'd4,
    ST_RUN      = 4'd5,
    ST_RDADDR   = 4'd6,
    ST_RDDATA   = 4'd7,
    ST_REPORT   = 4'd8
  } state_t;

  typedef enum logic [1:0] {
    STATUS_OK       = 2'b00,
    STATUS_TIMEOUT  = 2'b01,
    STATUS_NOT_IDLE = 2'b10,
    STATUS_OVERFLOW = 2'b11
  } status_t;

endpackage

// File: rtl/cpu_launcher_timer.sv
// launch_timer
//   Counts CPU run cycles and flags when the run budget is used up.
//   Ports:
//     clk     rising-edge clock
//     rst     asynchronous reset, active-low
//     clr     synchronous clear of the cycle counter
//     en      count this cycle
//     expired high while the counter equals TIMEOUT-1
module launch_timer #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  // At least one bit so TIMEOUT=1 still elaborates.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  assign expired = (count_reg == CW'(TIMEOUT - 1));

endmodule

// File: rtl/cpu_launcher.sv
// cpu_launcher
//   Loads a program image into CPU memory, releases the CPU from reset,
//   strobes it to start, waits for the PC to reach halt_addr (or a timeout),
//   then reads one result byte back and reports it with a status code.
//   Ports:
//     clk, rst                      clock / async active-low reset
//     ld_valid/ld_data/ld_last      host program byte stream
//     ld_ready                      byte accepted when high with ld_valid
//     go, halt_addr, res_addr       run request and its parameters
//     busy, result, result_valid,   run status and report
//     status
//     mem_sel/we/addr/wdata/rdata   shared memory port (rdata 1-cycle latency)
//     cpu_rst, cpu_start            CPU control
//     cpu_done, cpu_pc              CPU observation
module cpu_launcher
  import cpu_launcher_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic              go,
  input  logic [ADDR_W-1:0] halt_addr,
  input  logic [ADDR_W-1:0] res_addr,
  output logic              busy,
  output logic [7:0]        result,
  output logic              result_valid,
  output logic [1:0]        status,
  output logic              mem_sel,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              cpu_rst,
  output logic              cpu_start,
  input  logic              cpu_done,
  input  logic [ADDR_W-1:0] cpu_pc
);

  // Pointer carries one extra bit so a wrap past the top address is visible.
  localparam int PW = ADDR_W + 1;

  state_t        state_reg, state_next;
  logic [PW-1:0] ptr_reg, ptr_next;
  logic [7:0]    result_reg, result_next;
  status_t       status_reg, status_next;
  // Run outcome remembered until the result byte arrives, so that the
  // visible status only changes together with result on entry to REPORT.
  status_t       pend_reg, pend_next;

  logic overflow;
  logic wr;
  logic tmr_clr;
  logic tmr_en;
  logic expired;

  assign overflow = ptr_reg[ADDR_W];

  // Gated by rst so nothing is accepted or written while reset is held.
  assign ld_ready = rst && ((state_reg == ST_IDLE) || (state_reg == ST_LOAD));
  assign wr       = ld_ready && ld_valid && !((state_reg == ST_LOAD) && overflow);

  assign mem_we    = wr;
  assign mem_wdata = wr ? ld_data : 8'h00;

  assign busy         = (state_reg != ST_IDLE);
  assign result_valid = (state_reg == ST_REPORT);
  assign cpu_start    = (state_reg == ST_START_HI);
  // The CPU owns memory and runs out of reset only across the launch window.
  assign mem_sel = !((state_reg == ST_START_HI) || (state_reg == ST_START_LO) ||
                     (state_reg == ST_RUN));
  assign cpu_rst = !((state_reg == ST_ARM) || (state_reg == ST_START_HI) ||
                     (state_reg == ST_START_LO) || (state_reg == ST_RUN));
  assign result = result_reg;
  assign status = status_reg;

  launch_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_reg    <= '0;
      result_reg <= 8'h00;
      status_reg <= STATUS_OK;
      pend_reg   <= STATUS_OK;
    end else begin
      ptr_reg    <= ptr_next;
      result_reg <= result_next;
      status_reg <= status_next;
      pend_reg   <= pend_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    ptr_next    = ptr_reg;
    result_next = result_reg;
    status_next = status_reg;
    pend_next   = pend_reg;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;
    mem_addr    = '0;

    case (state_reg)
      ST_IDLE: begin
        // A load byte wins over go; the first byte always lands at 0.
        if (ld_valid) begin
          ptr_next   = PW'(1);
          state_next = ld_last ? ST_IDLE : ST_LOAD;
        end else if (go) begin
          state_next = ST_ARM;
        end
      end
      ST_LOAD: begin
        mem_addr = ptr_reg[ADDR_W-1:0];
        if (ld_valid) begin
          if (overflow) begin
            status_next = STATUS_OVERFLOW;
            result_next = 8'h00;
            state_next  = ST_REPORT;
          end else begin
            ptr_next = ptr_reg + PW'(1);
            if (ld_last) begin
              state_next = ST_IDLE;
            end
          end
        end
      end
      ST_ARM: begin
        if (cpu_done) begin
          state_next = ST_START_HI;
        end else begin
          status_next = STATUS_NOT_IDLE;
          result_next = 8'h00;
          state_next  = ST_REPORT;
        end
      end
      ST_START_HI: state_next = ST_START_LO;
      ST_START_LO: begin
        // Clearing here makes the counter read 0 in the first RUN cycle.
        tmr_clr    = 1'b1;
        state_next = ST_RUN;
      end
      ST_RUN: begin
        tmr_en = 1'b1;
        if (cpu_pc == halt_addr) begin
          pend_next  = STATUS_OK;
          state_next = ST_RDADDR;
        end else if (expired) begin
          pend_next  = STATUS_TIMEOUT;
          state_next = ST_RDADDR;
        end
      end
      ST_RDADDR: begin
        mem_addr   = res_addr;
        state_next = ST_RDDATA;
      end
      ST_RDDATA: begin
        result_next = mem_rdata;
        status_next = pend_reg;
        state_next  = ST_REPORT;
      end
      ST_REPORT: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_launcher.sv
// tb_cpu_launcher
//   Randomized self-checking bench for cpu_launcher. A behavioural memory and
//   a scripted CPU surround the main instance (ADDR_W=13, TIMEOUT=16); a second
//   instance with ADDR_W=2 exercises load overflow.
module tb_cpu_launcher;

  localparam int AW  = 13;
  localparam int TO  = 16;
  localparam int SAW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          ld_valid, ld_last, go, cpu_done;
  logic [7:0]    ld_data;
  logic [AW-1:0] halt_addr, res_addr, cpu_pc;
  logic          ld_ready, busy, result_valid, mem_sel, mem_we, cpu_rst, cpu_start;
  logic [7:0]    result, mem_wdata, mem_rdata;
  logic [1:0]    status;
  logic [AW-1:0] mem_addr;

  logic           s_ld_valid, s_ld_last;
  logic [7:0]     s_ld_data;
  logic           s_ld_ready, s_busy, s_result_valid, s_mem_sel, s_mem_we;
  logic           s_cpu_rst, s_cpu_start;
  logic [7:0]     s_result, s_mem_wdata;
  logic [1:0]     s_status;
  logic [SAW-1:0] s_mem_addr;

  cpu_launcher #(.ADDR_W(AW), .TIMEOUT(TO)) u_dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .go(go), .halt_addr(halt_addr), .res_addr(res_addr),
    .busy(busy), .result(result), .result_valid(result_valid), .status(status),
    .mem_sel(mem_sel), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .cpu_rst(cpu_rst), .cpu_start(cpu_start),
    .cpu_done(cpu_done), .cpu_pc(cpu_pc)
  );

  cpu_launcher #(.ADDR_W(SAW), .TIMEOUT(TO)) u_small (
    .clk(clk), .rst(rst),
    .ld_valid(s_ld_valid), .ld_data(s_ld_data), .ld_last(s_ld_last), .ld_ready(s_ld_ready),
    .go(1'b0), .halt_addr(2'b00), .res_addr(2'b00),
    .busy(s_busy), .result(s_result), .result_valid(s_result_valid), .status(s_status),
    .mem_sel(s_mem_sel), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .mem_rdata(8'h00), .cpu_rst(s_cpu_rst), .cpu_start(s_cpu_start),
    .cpu_done(1'b0), .cpu_pc(2'b00)
  );

  // Behavioural memory on the shared port plus a bench backdoor write.
  logic [7:0]    mem     [0:(1<<AW)-1];
  logic [7:0]    ref_mem [0:(1<<AW)-1];
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [7:0]    bd_data;

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (mem_sel && mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  int checks = 0;
  int errors = 0;

  logic [7:0] lbytes [0:15];
  logic [7:0] last_res;
  logic [1:0] last_st;
  bit         res_known;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic backdoor(input logic [AW-1:0] a, input logic [7:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
    ref_mem[a] = d;
  endtask

  // Loads lbytes[0..n-1] with ld_last on the final byte; starts and ends at
  // posedge+1 with the launcher idle.
  task automatic load_seq(input int n);
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1; ld_data = lbytes[i]; ld_last = (i == n - 1);
      go = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("ld_ready", ld_ready, 1);
      check("load_we", mem_we, 1);
      check("load_addr", mem_addr, i);
      check("load_wdata", mem_wdata, lbytes[i]);
      ref_mem[i] = lbytes[i];
      @(posedge clk); #1;
    end
    ld_valid = 1'b0; ld_last = 1'b0; go = 1'b0;
    @(negedge clk);
    check("load_idle_busy", busy, 0);
    check("hold_status", status, last_st);
    if (res_known) check("hold_result", result, last_res);
    for (int i = 0; i < n; i++) check("mem_image", mem[i], ref_mem[i]);
    @(posedge clk); #1;
  endtask

  // One go request. halt_k: RUN cycle (1-based) in which cpu_pc hits
  // halt_addr, 0 = never. Starts and ends at posedge+1 while idle.
  task automatic run_once(input bit done_in, input int halt_k,
                          input logic [AW-1:0] h, input logic [AW-1:0] r);
    int cyc, t_start, starts, rv_cyc, ldr_hits, we_hits, exp_len, exp_rv;
    bit seen, got_crst;
    logic [7:0] got_res;
    logic [1:0] got_st, exp_st;
    exp_len = 0;
    if (!done_in) begin
      exp_st = 2'b10; exp_rv = 1;
    end else begin
      if (halt_k >= 1 && halt_k <= TO) begin exp_st = 2'b00; exp_len = halt_k; end
      else begin exp_st = 2'b01; exp_len = TO; end
      exp_rv = exp_len + 5;  // ARM, START_HI, START_LO, RUN x len, RDADDR, RDDATA -> REPORT
    end
    halt_addr = h; res_addr = r; cpu_done = done_in; go = 1'b1;
    cpu_pc = h + AW'(1);
    @(posedge clk); #1;
    cyc = 0; t_start = -1; starts = 0; rv_cyc = -1; ldr_hits = 0; we_hits = 0;
    seen = 1'b0; got_crst = 1'b0; got_res = 8'h00; got_st = 2'b00;
    while (!seen && cyc < 200) begin
      go = 1'($urandom_range(0, 1));
      ld_valid = 1'($urandom_range(0, 1));
      ld_data = 8'($urandom);
      if (done_in && halt_k > 0 && t_start >= 0 && cyc == t_start + 1 + halt_k) cpu_pc = h;
      else cpu_pc = h + AW'(1 + $urandom_range(0, 99));
      @(negedge clk);
      if (cpu_start) begin starts++; if (t_start < 0) t_start = cyc; end
      if (ld_ready) ldr_hits++;
      if (mem_we) we_hits++;
      if (result_valid) begin
        seen = 1'b1; rv_cyc = cyc; got_res = result; got_st = status; got_crst = cpu_rst;
      end
      @(posedge clk); #1;
      cyc++;
    end
    go = 1'b0; ld_valid = 1'b0;
    check("run_result_valid_seen", seen, 1);
    if (seen) begin
      check("run_start_pulses", starts, done_in ? 1 : 0);
      check("run_rv_cycle", rv_cyc, exp_rv);
      check("run_status", got_st, exp_st);
      if (done_in) check("run_result", got_res, ref_mem[r]);
      check("run_report_cpu_rst", got_crst, 1);
      check("run_ld_ready_off", ldr_hits, 0);
      check("run_no_write", we_hits, 0);
      @(negedge clk);
      check("run_end_busy", busy, 0);
      check("run_end_cpu_rst", cpu_rst, 1);
      check("run_rv_one_cycle", result_valid, 0);
      @(posedge clk); #1;
      last_st = exp_st;
      res_known = done_in;
      if (done_in) last_res = ref_mem[r];
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int rv_hits, busy_hits;
    logic [AW-1:0] a;
    ld_valid = 0; ld_last = 0; ld_data = 0; go = 0; cpu_done = 0;
    halt_addr = 0; res_addr = 0; cpu_pc = 0;
    s_ld_valid = 0; s_ld_last = 0; s_ld_data = 0;
    bd_we = 0; bd_addr = 0; bd_data = 0;
    last_res = 8'h00; last_st = 2'b00; res_known = 1'b1;

    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_cpu_start", cpu_start, 0);
    check("rst_mem_sel", mem_sel, 1);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_result", result, 0);
    check("rst_status", status, 0);
    check("rst_result_valid", result_valid, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed program load, then a halting run reading 0x100.
    lbytes[0] = 8'h20; lbytes[1] = 8'h41; lbytes[2] = 8'hC0; lbytes[3] = 8'h03;
    load_seq(4);
    backdoor(13'h100, 8'h5A);
    run_once(1'b1, 10, 13'h003, 13'h100);
    // Never halts: timeout after exactly TO RUN cycles.
    run_once(1'b1, 0, 13'h003, 13'h100);
    // CPU not idle at ARM.
    run_once(1'b0, 0, 13'h003, 13'h100);
    // Halt in the last allowed cycle and one past it.
    run_once(1'b1, TO, 13'h003, 13'h100);
    run_once(1'b1, TO + 1, 13'h003, 13'h100);

    // Overflow on the 4-entry instance: 4 writes, 5th rejected.
    for (int i = 0; i < 5; i++) begin
      s_ld_valid = 1'b1; s_ld_data = 8'(8'h10 + i); s_ld_last = 1'b0;
      @(negedge clk);
      if (i < 4) begin
        check("ovf_write_we", s_mem_we, 1);
        check("ovf_write_addr", s_mem_addr, i);
      end else begin
        check("ovf_reject_we", s_mem_we, 0);
      end
      @(posedge clk); #1;
    end
    s_ld_valid = 1'b0;
    @(negedge clk);
    check("ovf_result_valid", s_result_valid, 1);
    check("ovf_status", s_status, 2'b11);
    check("ovf_result", s_result, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("ovf_idle", s_busy, 0);
    @(posedge clk); #1;

    // Randomized load/run rounds.
    for (int t = 0; t < 10; t++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) lbytes[i] = 8'($urandom);
      load_seq(n);
      a = AW'($urandom_range(16, (1 << AW) - 1));
      backdoor(a, 8'($urandom));
      run_once($urandom_range(0, 4) != 0, $urandom_range(0, TO + 4), AW'($urandom), a);
    end

    // Reset asserted in RUN cycle 5.
    cpu_done = 1'b1; halt_addr = 13'h003; res_addr = 13'h100; cpu_pc = 13'h040; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("rr_running_busy", busy, 1);
    check("rr_running_cpu_rst", cpu_rst, 0);
    #2 rst = 1'b0;
    #1;
    check("rr_busy", busy, 0);
    check("rr_cpu_rst", cpu_rst, 1);
    check("rr_mem_sel", mem_sel, 1);
    check("rr_mem_we", mem_we, 0);
    check("rr_cpu_start", cpu_start, 0);
    check("rr_result_valid", result_valid, 0);
    check("rr_result", result, 0);
    check("rr_status", status, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    rv_hits = 0; busy_hits = 0;
    repeat (30) begin
      @(negedge clk);
      if (result_valid) rv_hits++;
      if (busy) busy_hits++;
    end
    check("rr_no_report", rv_hits, 0);
    check("rr_stays_idle", busy_hits, 0);
    @(posedge clk); #1;
    last_res = 8'h00; last_st = 2'b00; res_known = 1'b1;

    // Recovery after reset.
    lbytes[0] = 8'hA5;
    load_seq(1);
    run_once(1'b1, 5, 13'h003, 13'h100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
